// File: rtl/usb_rx_packet_ctrl_pkg.sv
// Shared USB receive definitions: PID codes, payload limit, controller state type.
package usb_rx_packet_ctrl_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam int MAX_PAYLOAD = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_TOKEN, ST_DATA, ST_IGNORE} state_t;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_crc_strip.sv
// Two-byte delay line that hides the trailing CRC16 bytes and counts forwarded payload.
module usb_crc_strip
  import usb_rx_packet_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_strobe,
  input  logic [7:0] i_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_short,
  output logic       o_ovf
);

  logic [7:0] r_dly0;
  logic [7:0] r_dly1;
  logic [1:0] r_fill;
  logic [6:0] r_fwd;
  logic       r_ovf;
  logic       w_push;

  assign w_push  = i_en & i_strobe;
  assign o_short = (r_fill != 2'd2);
  assign o_ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dly0 <= i_data;
      r_dly1 <= r_dly0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill       <= 2'd0;
      r_fwd        <= 7'd0;
      r_ovf        <= 1'b0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (i_clr) begin
        r_fill <= 2'd0;
        r_fwd  <= 7'd0;
        r_ovf  <= 1'b0;
      end else if (w_push) begin
        if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
        // A byte is payload only once two newer bytes have arrived behind it.
        if (r_fill == 2'd2) begin
          if (r_fwd == 7'(MAX_PAYLOAD)) begin
            r_ovf <= 1'b1;
          end else begin
            o_byte       <= r_dly1;
            o_byte_valid <= 1'b1;
            r_fwd        <= r_fwd + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB device receive packet controller: token decode, SOF capture, OUT/SETUP data phase
// with toggle tracking and handshake request generation.
module usb_rx_packet_ctrl
  import usb_rx_packet_ctrl_pkg::*;
(
  input  logic        clk_48,
  input  logic        rst,
  input  logic [3:0]  xpid,
  input  logic [7:0]  xdata,
  input  logic        xpacket,
  input  logic        xdatastrobe,
  input  logic        xcrc5_ok,
  input  logic        xcrc16_ok,
  input  logic        usb_rst,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] ep_ready,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [3:0]  tok_ep,
  output logic        sof_valid,
  output logic [10:0] frame_num,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_commit,
  output logic        rx_abort,
  output logic        hs_req,
  output logic [3:0]  hs_pid,
  output logic        ack_rcvd
);

  state_t      r_state;
  logic        r_pkt_d;
  logic [3:0]  r_pid;
  logic [3:0]  r_ep;
  logic        r_armed;
  logic [3:0]  r_arm_ep;
  logic [15:0] r_toggle;
  logic [1:0]  r_tcnt;
  logic [7:0]  r_b0;
  logic [2:0]  r_b1;
  logic        w_start;
  logic        w_end;
  logic        w_short;
  logic        w_ovf;
  logic [3:0]  w_tok_ep;
  logic [3:0]  w_exp_pid;

  assign w_start   = xpacket & ~r_pkt_d;
  assign w_end     = ~xpacket & r_pkt_d;
  assign w_tok_ep  = {r_b1, r_b0[7]};
  assign w_exp_pid = r_toggle[r_ep] ? PID_DATA1 : PID_DATA0;

  usb_crc_strip u_strip (
    .clk          (clk_48),
    .rst          (rst),
    .i_clr        (w_start),
    .i_en         (r_state == ST_DATA),
    .i_strobe     (xdatastrobe),
    .i_data       (xdata),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_byte_valid),
    .o_short      (w_short),
    .o_ovf        (w_ovf)
  );

  always_ff @(posedge clk_48) begin
    if (xdatastrobe && r_state == ST_TOKEN) begin
      if (r_tcnt == 2'd0) r_b0 <= xdata;
      if (r_tcnt == 2'd1) r_b1 <= xdata[2:0];
    end
  end

  // r_pkt_d resets high so a packet already in flight at reset release is never seen as a start.
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pkt_d   <= 1'b1;
      r_pid     <= 4'd0;
      r_ep      <= 4'd0;
      r_armed   <= 1'b0;
      r_arm_ep  <= 4'd0;
      r_toggle  <= 16'd0;
      r_tcnt    <= 2'd0;
      frame_num <= 11'd0;
      tok_valid <= 1'b0;
      tok_pid   <= 4'd0;
      tok_ep    <= 4'd0;
      sof_valid <= 1'b0;
      rx_commit <= 1'b0;
      rx_abort  <= 1'b0;
      hs_req    <= 1'b0;
      hs_pid    <= 4'd0;
      ack_rcvd  <= 1'b0;
    end else begin
      r_pkt_d   <= xpacket;
      tok_valid <= 1'b0;
      sof_valid <= 1'b0;
      rx_commit <= 1'b0;
      rx_abort  <= 1'b0;
      hs_req    <= 1'b0;
      ack_rcvd  <= 1'b0;
      if (usb_rst) begin
        r_toggle <= 16'd0;
        r_armed  <= 1'b0;
        r_state  <= ST_IDLE;
        if (r_state == ST_DATA) rx_abort <= 1'b1;
      end else if (w_start) begin
        // A start while still in DATA means the previous end was lost.
        if (r_state == ST_DATA) rx_abort <= 1'b1;
        r_pid  <= xpid;
        r_tcnt <= 2'd0;
        if (is_token(xpid)) begin
          r_state <= ST_TOKEN;
          r_armed <= 1'b0;
        end else if (is_data(xpid) && r_armed) begin
          r_state <= ST_DATA;
          r_ep    <= r_arm_ep;
        end else begin
          r_armed <= 1'b0;
          if (xpid == PID_ACK) begin
            ack_rcvd <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_state <= ST_IGNORE;
          end
        end
      end else if (w_end) begin
        r_state <= ST_IDLE;
        case (r_state)
          ST_TOKEN: begin
            if (r_tcnt == 2'd2 && xcrc5_ok) begin
              if (r_pid == PID_SOF) begin
                frame_num <= {r_b1, r_b0};
                sof_valid <= 1'b1;
              end else if (r_b0[6:0] == dev_addr) begin
                tok_valid <= 1'b1;
                tok_pid   <= r_pid;
                tok_ep    <= w_tok_ep;
                if (r_pid == PID_OUT || r_pid == PID_SETUP) begin
                  r_armed  <= 1'b1;
                  r_arm_ep <= w_tok_ep;
                end
                if (r_pid == PID_SETUP) r_toggle[w_tok_ep] <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (!xcrc16_ok || w_short || w_ovf) begin
              rx_abort <= 1'b1;
            end else begin
              hs_req <= 1'b1;
              if (!ep_ready[r_ep]) begin
                rx_abort <= 1'b1;
                hs_pid   <= PID_NAK;
              end else begin
                hs_pid <= PID_ACK;
                if (r_pid == w_exp_pid) begin
                  rx_commit        <= 1'b1;
                  r_toggle[r_ep]   <= ~r_toggle[r_ep];
                end else begin
                  rx_abort <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end else if (xdatastrobe && r_state == ST_TOKEN && r_tcnt != 2'd3) begin
        r_tcnt <= r_tcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Scoreboard bench for usb_rx_packet_ctrl: directed packets push expected events, a monitor pops them.
module tb_usb_rx_packet_ctrl;

  localparam logic [3:0] P_OUT = 4'b0001, P_SOF = 4'b0101, P_SETUP = 4'b1101;
  localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011, P_ACK = 4'b0010, P_NAK = 4'b1010;
  localparam logic [2:0] K_TOK = 3'd1, K_SOF = 3'd2, K_BYTE = 3'd3, K_END = 3'd4, K_ACKR = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  xpid;
  logic [7:0]  xdata;
  logic        xpacket, xdatastrobe, xcrc5_ok, xcrc16_ok, usb_rst;
  logic [6:0]  dev_addr;
  logic [15:0] ep_ready;
  logic        tok_valid, sof_valid, rx_byte_valid, rx_commit, rx_abort, hs_req, ack_rcvd;
  logic [3:0]  tok_pid, tok_ep, hs_pid;
  logic [10:0] frame_num;
  logic [7:0]  rx_byte;

  ev_t         exp_q[$];
  logic [7:0]  pbuf[0:79];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  usb_rx_packet_ctrl dut (
    .clk_48(clk), .rst(rst), .xpid(xpid), .xdata(xdata), .xpacket(xpacket),
    .xdatastrobe(xdatastrobe), .xcrc5_ok(xcrc5_ok), .xcrc16_ok(xcrc16_ok),
    .usb_rst(usb_rst), .dev_addr(dev_addr), .ep_ready(ep_ready),
    .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_ep(tok_ep), .sof_valid(sof_valid),
    .frame_num(frame_num), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_commit(rx_commit), .rx_abort(rx_abort), .hs_req(hs_req), .hs_pid(hs_pid),
    .ack_rcvd(ack_rcvd)
  );

  function automatic logic [15:0] end_val(input logic c, input logic a, input logic h,
                                          input logic [3:0] p);
    return {9'd0, c, a, h, (h ? p : 4'd0)};
  endfunction

  task automatic expect_ev(input logic [2:0] k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [2:0] k, input logic [15:0] v, input string name);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event val=%h, nothing expected", name, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_err++;
        $display("FAIL %s: got kind=%0d val=%h, expected kind=%0d val=%h", name, k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tok_valid) check_ev(K_TOK, {8'd0, tok_pid, tok_ep}, "tok");
      if (sof_valid) check_ev(K_SOF, {5'd0, frame_num}, "sof");
      if (rx_byte_valid) check_ev(K_BYTE, {8'd0, rx_byte}, "rx_byte");
      if (rx_commit || rx_abort || hs_req)
        check_ev(K_END, end_val(rx_commit, rx_abort, hs_req, hs_pid), "end");
      if (ack_rcvd) check_ev(K_ACKR, 16'd1, "ack_rcvd");
    end
  end

  task automatic send_pkt(input logic [3:0] pid, input int n, input logic c5, input logic c16);
    @(posedge clk); #1;
    xpid = pid;
    xpacket = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      xdata = pbuf[i];
      xdatastrobe = 1'b1;
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
    end
    @(posedge clk); #1;
    xcrc5_ok = c5;
    xcrc16_ok = c16;
    xpacket = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xcrc5_ok = 1'b0;
    xcrc16_ok = 1'b0;
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                            input logic c5, input logic accept);
    pbuf[0] = {ep[0], addr};
    pbuf[1] = {5'd0, ep[3:1]};
    if (accept) expect_ev(K_TOK, {8'd0, pid, ep});
    send_pkt(pid, 2, c5, 1'b0);
  endtask

  // n counts every byte including the two CRC16 bytes; fwd payload bytes are expected out.
  task automatic send_data(input logic [3:0] pid, input int n, input logic c16, input int fwd,
                           input logic [15:0] endv);
    for (int i = 0; i < n; i++) pbuf[i] = 8'(8'hA0 + i);
    for (int i = 0; i < fwd; i++) expect_ev(K_BYTE, {8'd0, pbuf[i]});
    if (endv != 16'd0) expect_ev(K_END, endv);
    send_pkt(pid, n, 1'b1, c16);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d expected events never seen, expected 0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; xpid = 4'd0; xdata = 8'd0; xpacket = 1'b0; xdatastrobe = 1'b0;
    xcrc5_ok = 1'b0; xcrc16_ok = 1'b0; usb_rst = 1'b0; dev_addr = 7'd5; ep_ready = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("reset_pulses", {25'd0, tok_valid, sof_valid, rx_byte_valid, rx_commit, rx_abort,
                         hs_req, ack_rcvd}, 32'd0);
    chk("reset_frame_num", {21'd0, frame_num}, 32'd0);
    chk("reset_regs", {12'd0, tok_pid, tok_ep, hs_pid, rx_byte}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // OUT ep2 + DATA0 good -> commit, ACK; toggle[2] becomes 1
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D0, 5, 1'b1, 3, end_val(1'b1, 1'b0, 1'b1, P_ACK));
    drain("out_data0_commit");

    // retried DATA0 -> toggle mismatch abort with ACK
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D0, 5, 1'b1, 3, end_val(1'b0, 1'b1, 1'b1, P_ACK));
    drain("repeat_data0");

    // token to another address disarms; following DATA0 is ignored
    send_token(P_OUT, 7'd6, 4'd2, 1'b1, 1'b0);
    send_data(P_D0, 5, 1'b1, 0, 16'd0);
    drain("wrong_addr");

    // endpoint busy -> NAK
    ep_ready = 16'hFFFB;
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D1, 5, 1'b1, 3, end_val(1'b0, 1'b1, 1'b1, P_NAK));
    drain("ep_busy_nak");
    ep_ready = 16'hFFFF;

    // bad CRC16 -> silent abort, hs_pid keeps its last value
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D1, 5, 1'b0, 3, end_val(1'b0, 1'b1, 1'b0, 4'd0));
    drain("bad_crc16");
    chk("hs_pid_hold", {28'd0, hs_pid}, {28'd0, P_NAK});

    // SOF frame {b1[2:0], b0}
    pbuf[0] = 8'h34;
    pbuf[1] = 8'h05;
    expect_ev(K_SOF, 16'h0534);
    send_pkt(P_SOF, 2, 1'b1, 1'b0);
    drain("sof");

    // 66-byte payload with correct toggle: 64 forwarded then overflow abort
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D1, 68, 1'b1, 64, end_val(1'b0, 1'b1, 1'b0, 4'd0));
    drain("overflow");

    // SETUP clears toggle[2] (currently 1) so DATA0 commits
    send_token(P_SETUP, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D0, 4, 1'b1, 2, end_val(1'b1, 1'b0, 1'b1, P_ACK));
    drain("setup_data0");

    // usb_rst in the middle of DATA -> abort; toggle[2] was 1 and must clear
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) pbuf[i] = 8'(8'h50 + i);
    expect_ev(K_BYTE, 16'h0050);
    expect_ev(K_END, end_val(1'b0, 1'b1, 1'b0, 4'd0));
    @(posedge clk); #1;
    xpid = P_D1;
    xpacket = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      xdata = pbuf[i];
      xdatastrobe = 1'b1;
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
    end
    @(posedge clk); #1 usb_rst = 1'b1;
    @(posedge clk); #1 usb_rst = 1'b0;
    @(posedge clk); #1 xpacket = 1'b0;
    repeat (4) @(posedge clk);
    drain("usb_rst_mid_data");
    send_token(P_OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    send_data(P_D0, 5, 1'b1, 3, end_val(1'b1, 1'b0, 1'b1, P_ACK));
    drain("toggle_cleared");

    // host ACK packet
    expect_ev(K_ACKR, 16'd1);
    send_pkt(P_ACK, 0, 1'b0, 1'b0);
    drain("ack_rcvd");

    // token with bad CRC5 is dropped and does not arm
    send_token(P_OUT, 7'd5, 4'd2, 1'b0, 1'b0);
    send_data(P_D1, 5, 1'b1, 0, 16'd0);
    drain("bad_crc5");

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_ctrl.md
USB_RX_PACKET_CTRL -- requirements
Module: usb_rx_packet_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first):
 - clk_48  in  1  — sole clock.
 - rst  in  1  — asynchronous, active-high reset.
 - xpid  in  4  — PID of the current packet.
 - xdata  in  8  — received byte.
 - xpacket  in  1  — high while a packet is in progress.
 - xdatastrobe  in  1  — one-cycle pulse per byte.
 - xcrc5_ok, xcrc16_ok  in  1 each  — CRC status after the last byte.
 - usb_rst  in  1  — bus reset.
 - dev_addr  in  7  — device address.
 - ep_ready  in  16  — per-endpoint OUT buffer free.
 - tok_valid  out  1  — token accepted, one-cycle pulse.
 - tok_pid  out  4  — accepted token PID.
 - tok_ep  out  4  — accepted token endpoint.
 - sof_valid  out  1  — SOF accepted, one-cycle pulse.
 - frame_num  out  11  — last SOF frame number.
 - rx_byte  out  8  — payload byte.
 - rx_byte_valid  out  1  — payload byte strobe.
 - rx_commit, rx_abort  out  1 each  — end-of-data outcome pulses.
 - hs_req  out  1  — handshake request pulse.
 - hs_pid  out  4  — PID of the requested handshake.
 - ack_rcvd  out  1  — host ACK received.
REQ-002 SHALL use one clock, clk_48; reset is asynchronous and active-high on port rst.
REQ-003 SHALL use PID constants: OUT=0001, IN=1001, SOF=0101, SETUP=1101, DATA0=0011, DATA1=1011, ACK=0010, NAK=1010.

Function
REQ-004 SHALL implement states IDLE, TOKEN, DATA, IGNORE.
REQ-005 SHALL define packet start as a rising edge of xpacket and packet end as a falling edge of xpacket.
REQ-006 On packet start, the next state SHALL be selected by xpid:
 - token PIDs (OUT/IN/SOF/SETUP) -> TOKEN;
 - DATA0/DATA1 while armed -> DATA;
 - ACK -> IDLE, with ack_rcvd pulsed once;
 - anything else -> IGNORE.
REQ-007 SHALL accept a token at packet end only if exactly 2 bytes were received and xcrc5_ok=1.
REQ-008 Token field mapping SHALL be: addr=b0[6:0]; ep={b1[2:0],b0[7]}; SOF frame={b1[2:0],b0}.
REQ-009 An SOF SHALL update frame_num and pulse sof_valid regardless of address.
REQ-010 OUT/IN/SETUP tokens SHALL pulse tok_valid/tok_pid/tok_ep only when addr==dev_addr; otherwise they are silently dropped.
REQ-011 An accepted OUT/SETUP SHALL arm a data phase for tok_ep.
 - SETUP SHALL clear that endpoint's expected toggle to DATA0.
 - Any subsequent packet that is not DATA0/DATA1 SHALL disarm.
REQ-012 In DATA, payload bytes SHALL be forwarded through a 2-byte delay so the CRC16 bytes are never emitted.
 - rx_byte_valid pulses 1 cycle after the xdatastrobe that displaces a byte from the delay.
REQ-013 The payload limit SHALL be 64 bytes; a 65th payload byte SHALL set an overflow flag and suppress further forwarding.
REQ-014 At DATA packet end, exactly one of rx_commit/rx_abort SHALL pulse, 1 cycle after the xpacket fall, per these rules:
 - crc16 bad, or byte count <2, or overflow -> rx_abort, no hs_req.
 - ep_ready[ep]=0 -> rx_abort, hs_req with NAK.
 - DATA PID != expected toggle -> rx_abort, hs_req with ACK, toggle unchanged.
 - otherwise -> rx_commit, hs_req with ACK, toggle[ep] inverted.
REQ-015 hs_req SHALL pulse in the same cycle as rx_commit/rx_abort; hs_pid SHALL hold until the next hs_req.
REQ-016 A packet end with the state machine in TOKEN/DATA but without a matching start SHALL return to IDLE without output pulses.
REQ-017 usb_rst=1 SHALL, synchronously:
 - clear all 16 toggles;
 - disarm any data phase;
 - force IDLE;
 - emit rx_abort if DATA was active.
REQ-018 A packet start arriving while not in IDLE (a lost end) SHALL, in DATA, abort the current packet (rx_abort) and then process the new start.
REQ-019 All output pulses SHALL be exactly one cycle wide.

Reset
REQ-020 rst SHALL force:
 - state to IDLE, disarmed;
 - toggles to 0;
 - frame_num to 0;
 - all pulse outputs to 0;
 - tok_pid, tok_ep, hs_pid, rx_byte to 0.
REQ-021 A reset asserted mid-packet SHALL discard the packet; forwarding resumes only after a fresh packet start following deassertion.

Structure
REQ-022 PID constants and the 64-byte limit SHALL live in the shared USB definitions include file.
REQ-023 The 2-byte CRC-strip delay and byte counter SHALL be a sub-module, usb_crc_strip.

Verification
REQ-024 Directed scenarios the bench SHALL cover:
 - OUT token addr=5 ep=2 (dev_addr=5), then DATA0 with 3 payload bytes and good CRC -> tok_valid, 3 rx_byte_valid, rx_commit, hs ACK, toggle[2]=1.
 - Repeat the same DATA0 -> rx_abort, hs ACK, toggle[2] stays 1.
 - OUT to addr=6 with dev_addr=5, then DATA0 -> no tok_valid, packet IGNOREd, no hs_req.
 - ep_ready[2]=0, OUT+DATA1 -> rx_abort, hs NAK.
 - DATA packet with bad CRC16 -> rx_abort, no hs_req.
 - SOF with b0=0x34, b1=0x05 -> frame_num=0x534, sof_valid.
 - 66-byte payload -> 64 bytes forwarded, then rx_abort.
 - usb_rst mid-DATA -> rx_abort, all toggles 0.
